kmer_match_2b: RTL and testbench
================================

# kmer_match_2b

Downstream consumer of the 2-bit symbol shifter. Accepts one 2-bit symbol per cycle, keeps a sliding window of the last K symbols, and compares it against a programmable K-symbol pattern. Each hit is queued in a small result buffer as the start position of the match, for host readout. The block drives the shifter's enable from its own buffer occupancy, so no symbol is ever dropped.

## Interface
- `K`, 16: pattern length in symbols. Range 1..16.
- `DEPTH`, 4: result buffer entries. Minimum 3.
- `POS_W`, 32: width of the position and count fields.

- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: **asynchronous, active-low** reset.
- `sym_in`, in, 2: symbol from the upstream shifter's data output.
- `sym_in_valid`, in, 1: upstream data-valid flag.
- `sym_ready`, out, 1: registered; drives the upstream `sr_en`.
- `pattern`, in, 2K: search pattern. Bits [2K-1:2K-2] hold the first (oldest) symbol.
- `pattern_load`, in, 1: one-cycle pulse. Captures `pattern` and clears all run state.
- `match_pos`, out, POS_W: start index of the match at the head of the buffer.
- `match_valid`, out, 1: buffer is non-empty.
- `match_ready`, in, 1: consumer pop. A pop occurs when `match_valid && match_ready`.
- `match_count`, out, POS_W: total hits since the last load. Saturates at all-ones.
- `overflow`, out, 1: sticky flag; set when a hit arrives while the buffer is full.

## Operation
- Two states: IDLE and RUN. Reset enters IDLE.
- IDLE:
  - Symbols are accepted and discarded.
  - No hits are produced.
  - `sym_ready` follows the normal occupancy rule.
- `pattern_load` moves the block to RUN from any state. In the same edge it:
  - loads the pattern register;
  - clears the window, fill counter, symbol index, `match_count`, result buffer and `overflow`.
- `pattern_load` takes priority over a `sym_in_valid` or a pop in the same cycle. That symbol is discarded and that pop is lost.
- RUN, on each valid symbol:
  - window ← {window[2K-3:0], sym_in};
  - fill counter increments, saturating at K;
  - symbol index increments, modulo 2^POS_W; the first symbol after a load has index 0.
- A hit occurs when fill has reached K (including the current symbol) and the new window equals `pattern`.
- Hit handling:
  - push (index − (K−1)) mod 2^POS_W into the buffer;
  - increment `match_count`.
- Overlapping hits are all reported; for example, pattern AAAA on input AAAAA gives starts 0 and 1.
- Push and pop in the same cycle: occupancy is unchanged. This holds when full, because the pop frees the slot.
- Hit while the buffer is full and no pop in that cycle:
  - the entry is dropped;
  - `overflow` is set;
  - `match_count` still increments.
- `sym_ready` is registered. Its next value is (occupancy after this edge ≤ DEPTH−2).
  - Rationale: the upstream has a registered `sr_en`-to-valid path, so up to two symbols can be in flight after `sym_ready` is sampled.
  - With this rule a compliant upstream never causes an overflow.
- `sym_in_valid` is honoured even when `sym_ready` is low. Symbols are never back-pressured at this port.

## Timing
- Reset values:
  - `sym_ready` = 0; `match_valid` = 0; `match_pos` = 0; `match_count` = 0; `overflow` = 0.
  - State = IDLE; window and fill = 0.
- `sym_ready` rises on the first edge after `rst` deasserts.
- Hit to `match_valid`: 1 cycle. The push happens at the edge that samples the symbol; `match_valid` is high in the next cycle.
- `match_pos` and `match_valid` are registered and come from the buffer head. Pop to next entry: 1 cycle.
- `match_count` updates at the same edge as the push.
- `rst` asserted mid-run: every register clears immediately and asynchronously, and the pattern register returns to IDLE contents. A `pattern_load` is required before hits are reported again.

## Structure
- Package `sym2b_pkg` holds:
  - the symbol encoding constants A=2'b00, C=2'b01, G=2'b10, T=2'b11;
  - the `POS_W` default;
  - the `pos_t` typedef.
  The 32-to-2 shifter stage shares this package.
- One sub-module, `match_result_fifo`: synchronous FIFO, DEPTH × POS_W, registered head, exported occupancy count, same-cycle push and pop.
- Window compare, counters and the state machine live in the top level.

## Test plan
- Reset, then load K=4 with pattern ACGT (8'h1B); stream ACGTACGT → `match_pos` 0 then 4, `match_count` = 2.
- Load pattern AAAA; stream 6×A with `match_ready` held high → starts 0, 1, 2; `match_count` = 3.
- Hold `match_ready` low and model the upstream's 1-cycle `sr_en`-to-valid latency; stream ACGT repeated 10 times → `sym_ready` drops once occupancy reaches DEPTH−1; `overflow` stays 0; all 10 starts (0, 4, …, 36) are read back in order.
- Force `sym_in_valid` high with a full buffer and a hit present → `overflow` = 1; `match_count` still increments; buffer contents are unchanged.
- Assert `pattern_load` in the same cycle as a symbol that would complete a hit → no push; symbol index is 0 for the next symbol; `overflow` and the buffer are cleared.
- Assert `rst` (low) mid-stream with 2 entries queued → all outputs drop to their reset values immediately; stream after deassert without a load → no hits.

Source files
------------

// File: rtl/sym2b_pkg.sv
// Shared definitions for the 2-bit symbol datapath (shifter stage and k-mer matcher).
package sym2b_pkg;
  localparam logic [1:0] SYM_A = 2'b00;
  localparam logic [1:0] SYM_C = 2'b01;
  localparam logic [1:0] SYM_G = 2'b10;
  localparam logic [1:0] SYM_T = 2'b11;

  localparam int POS_W_DEF = 32;

  typedef logic [POS_W_DEF-1:0] pos_t;
endpackage

// File: rtl/match_result_fifo.sv
// Shift-register result FIFO with the head in a flop; push/pop same cycle, 1-cycle pop-to-next.
// A push into a full FIFO without a simultaneous pop is dropped; clr empties it in one edge.
module match_result_fifo
  import sym2b_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = POS_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head_dat,
  output logic                       head_vld,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     ent_q [DEPTH];
  logic [W-1:0]     ent_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d, base;
  logic             vld_q;
  logic             pop_ok, push_ok;

  always_comb begin
    pop_ok  = pop && (cnt_q != '0);
    push_ok = push && ((cnt_q != CNT_W'(DEPTH)) || pop_ok);
    ent_d   = ent_q;
    base    = pop_ok ? cnt_q - CNT_W'(1) : cnt_q;
    if (pop_ok) begin
      for (int i = 0; i < DEPTH-1; i++) ent_d[i] = ent_q[i+1];
      ent_d[DEPTH-1] = '0;
    end
    // The new entry lands just above whatever survives the pop.
    if (push_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == base) ent_d[i] = push_dat;
      end
    end
    cnt_d = base + CNT_W'(push_ok);
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
      vld_q <= (cnt_d != '0);
    end
  end

  assign head_dat = ent_q[0];
  assign head_vld = vld_q;
  assign count    = cnt_q;
endmodule

// File: rtl/kmer_match_2b.sv
// Sliding K-symbol window compared against a loaded pattern; hit start positions queue 1 cycle later.
// Never back-pressures symbols; sym_ready (registered) throttles the upstream by buffer occupancy.
module kmer_match_2b
  import sym2b_pkg::*;
#(
  parameter int K     = 16,
  parameter int DEPTH = 4,
  parameter int POS_W = POS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sym_in,
  input  logic             sym_in_valid,
  output logic             sym_ready,
  input  logic [2*K-1:0]   pattern,
  input  logic             pattern_load,
  output logic [POS_W-1:0] match_pos,
  output logic             match_valid,
  input  logic             match_ready,
  output logic [POS_W-1:0] match_count,
  output logic             overflow
);
  localparam int FILL_W = $clog2(K+1);
  localparam int CNT_W  = $clog2(DEPTH+1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic [2*K-1:0]     pat_q, win_q, win_nxt;
  logic [2*K+1:0]     win_cat;
  logic [FILL_W-1:0]  fill_q, fill_nxt;
  logic [POS_W-1:0]   idx_q, count_q, hit_pos;
  logic               ovf_q, ready_q;
  logic               take, hit, pop, full, push_ok;
  logic [CNT_W-1:0]   fifo_cnt, occ_nxt;
  logic               fifo_vld;

  always_comb begin
    win_cat  = {win_q, sym_in};
    win_nxt  = win_cat[2*K-1:0];
    fill_nxt = (fill_q == FILL_W'(K)) ? fill_q : fill_q + FILL_W'(1);
    take     = (state_q == RUN) && sym_in_valid && !pattern_load;
    hit      = take && (fill_nxt == FILL_W'(K)) && (win_nxt == pat_q);
    hit_pos  = idx_q - POS_W'(K-1);
    pop      = fifo_vld && match_ready && !pattern_load;
    full     = (fifo_cnt == CNT_W'(DEPTH));
    push_ok  = hit && (!full || pop);
    // Upstream can still deliver two symbols after sampling sym_ready, so keep two slots spare.
    occ_nxt  = pattern_load ? '0 : fifo_cnt + CNT_W'(push_ok) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      win_q   <= '0;
      fill_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= (occ_nxt <= CNT_W'(DEPTH-2));
      if (pattern_load) begin
        state_q <= RUN;
        pat_q   <= pattern;
        win_q   <= '0;
        fill_q  <= '0;
        idx_q   <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (take) begin
        win_q  <= win_nxt;
        fill_q <= fill_nxt;
        idx_q  <= idx_q + POS_W'(1);
        if (hit && (count_q != '1)) count_q <= count_q + POS_W'(1);
        if (hit && full && !pop)    ovf_q   <= 1'b1;
      end
    end
  end

  match_result_fifo #(.DEPTH(DEPTH), .W(POS_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (pattern_load),
    .push     (hit),
    .push_dat (hit_pos),
    .pop      (pop),
    .head_dat (match_pos),
    .head_vld (fifo_vld),
    .count    (fifo_cnt)
  );

  assign match_valid = fifo_vld;
  assign match_count = count_q;
  assign overflow    = ovf_q;
  assign sym_ready   = ready_q;
endmodule

// File: tb/tb_kmer_match_2b.sv
// Bench for kmer_match_2b: directed scenarios plus random traffic against a queue-based reference.
module tb_kmer_match_2b;
  import sym2b_pkg::*;

  localparam int K     = 4;
  localparam int DEPTH = 4;
  localparam int POS_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       sym_in;
  logic             sym_in_valid;
  logic             sym_ready;
  logic [2*K-1:0]   pattern;
  logic             pattern_load;
  logic [POS_W-1:0] match_pos;
  logic             match_valid;
  logic             match_ready;
  logic [POS_W-1:0] match_count;
  logic             overflow;

  always #5 clk = ~clk;

  kmer_match_2b #(.K(K), .DEPTH(DEPTH), .POS_W(POS_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .sym_in       (sym_in),
    .sym_in_valid (sym_in_valid),
    .sym_ready    (sym_ready),
    .pattern      (pattern),
    .pattern_load (pattern_load),
    .match_pos    (match_pos),
    .match_valid  (match_valid),
    .match_ready  (match_ready),
    .match_count  (match_count),
    .overflow     (overflow)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: symbol history since load, queue of pending starts, plain counters.
  bit               m_run;
  logic [2*K-1:0]   m_pat;
  logic [1:0]       m_hist[$];
  int unsigned      m_idx, m_cnt;
  bit               m_ovf, m_ready;
  int unsigned      m_q[$];
  int unsigned      dut_pop[$];

  task automatic model_reset();
    m_run = 0; m_pat = '0; m_hist.delete(); m_idx = 0; m_cnt = 0;
    m_ovf = 0; m_q.delete(); m_ready = 0;
  endtask

  function automatic bit window_hit();
    if (m_hist.size() != K) return 0;
    for (int j = 0; j < K; j++)
      if (m_hist[j] != m_pat[2*(K-1-j) +: 2]) return 0;
    return 1;
  endfunction

  task automatic model_edge();
    bit pop;
    if (!rst) begin model_reset(); return; end
    pop = (m_q.size() > 0) && match_ready;
    if (pattern_load) begin
      m_run = 1; m_pat = pattern; m_hist.delete(); m_idx = 0; m_cnt = 0;
      m_ovf = 0; m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_run && sym_in_valid) begin
        m_hist.push_back(sym_in);
        if (m_hist.size() > K) void'(m_hist.pop_front());
        if (window_hit()) begin
          if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
          if (m_q.size() < DEPTH) m_q.push_back(m_idx - 32'(K-1));
          else m_ovf = 1;
        end
        m_idx++;
      end
    end
    m_ready = (m_q.size() <= DEPTH-2);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "/vld"}, match_valid, m_q.size() > 0);
    if (m_q.size() > 0) check({tag, "/pos"}, match_pos, m_q[0]);
    check({tag, "/cnt"}, match_count, m_cnt);
    check({tag, "/ovf"}, overflow, m_ovf);
    check({tag, "/rdy"}, sym_ready, m_ready);
  endtask

  task automatic cycle(input string tag);
    if (match_valid && match_ready && !pattern_load) dut_pop.push_back(match_pos);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  function automatic logic [1:0] enc(input byte c);
    case (c)
      "A": return SYM_A;
      "C": return SYM_C;
      "G": return SYM_G;
      default: return SYM_T;
    endcase
  endfunction

  task automatic stream_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) begin
      sym_in = enc(s[i]);
      sym_in_valid = 1;
      cycle(tag);
    end
    sym_in_valid = 0;
  endtask

  task automatic load(input logic [2*K-1:0] p, input string tag);
    pattern = p;
    pattern_load = 1;
    cycle(tag);
    pattern_load = 0;
  endtask

  string       src;
  int          k;
  bit          en_s, saw_low;
  logic [7:0]  rp;

  initial begin
    rst = 0; sym_in = '0; sym_in_valid = 0; pattern = '0; pattern_load = 0; match_ready = 0;
    model_reset();
    #2;
    compare_all("reset");
    check("reset/pos0", match_pos, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    cycle("rst_rel");

    // ACGT twice: starts 0 and 4
    load(8'h1B, "load1");
    stream_str("ACGTACGT", "s1");
    check("s1/count", match_count, 2);
    check("s1/head", match_pos, 0);
    dut_pop.delete();
    match_ready = 1;
    cycle("s1pop"); cycle("s1pop");
    match_ready = 0;
    check("s1/npop", dut_pop.size(), 2);
    for (int i = 0; i < dut_pop.size(); i++) check("s1/popval", dut_pop[i], 4*i);

    // Overlapping hits with consumer always ready
    load(8'h00, "load2");
    dut_pop.delete();
    match_ready = 1;
    stream_str("AAAAAA", "s2");
    cycle("s2"); cycle("s2");
    match_ready = 0;
    check("s2/count", match_count, 3);
    check("s2/npop", dut_pop.size(), 3);
    for (int i = 0; i < dut_pop.size(); i++) check("s2/popval", dut_pop[i], i);

    // Upstream with registered sr_en-to-valid; consumer stalls, then drains randomly
    load(8'h1B, "load3");
    dut_pop.delete();
    src = "";
    for (int i = 0; i < 10; i++) src = {src, "ACGT"};
    k = 0; saw_low = 0;
    for (int cyc = 0; cyc < 400 && dut_pop.size() < 10; cyc++) begin
      en_s = sym_ready;
      if (!sym_ready) saw_low = 1;
      match_ready = (cyc >= 30) ? 1'($urandom % 2) : 1'b0;
      cycle("s3");
      if (sym_in_valid) k++;
      sym_in_valid = en_s && (k < 40);
      if (k < 40) sym_in = enc(src[k]);
    end
    sym_in_valid = 0; match_ready = 0;
    check("s3/ready_dropped", saw_low, 1);
    check("s3/ovf", overflow, 0);
    check("s3/npop", dut_pop.size(), 10);
    for (int i = 0; i < dut_pop.size(); i++) check("s3/popval", dut_pop[i], 4*i);

    // Force symbols into a full buffer
    load(8'h1B, "load4");
    stream_str("ACGTACGTACGTACGTACGT", "s4");
    check("s4/ovf", overflow, 1);
    check("s4/count", match_count, 5);
    check("s4/head", match_pos, 0);

    // Load collides with a hit-completing symbol
    stream_str("ACG", "s5");
    sym_in = SYM_T; sym_in_valid = 1;
    load(8'h1B, "s5load");
    sym_in_valid = 0;
    check("s5/vld", match_valid, 0);
    check("s5/ovf", overflow, 0);
    check("s5/count", match_count, 0);
    stream_str("ACGT", "s5b");
    check("s5/head", match_pos, 0);

    // Asynchronous reset with two entries queued
    stream_str("ACGT", "s6");
    check("s6/count", match_count, 2);
    sym_in = SYM_A; sym_in_valid = 1;
    #3 rst = 0;
    #1;
    model_reset();
    compare_all("s6rst");
    check("s6/pos0", match_pos, 0);
    cycle("s6hold");
    rst = 1;
    stream_str("ACGTACGTACGT", "s6post");
    check("s6/nohit", match_count, 0);

    // Random traffic over a narrow alphabet so hits are frequent
    for (int j = 0; j < K; j++) rp[2*j +: 2] = ($urandom % 2) ? SYM_C : SYM_A;
    load(rp, "load7");
    for (int cyc = 0; cyc < 600; cyc++) begin
      sym_in_valid = ($urandom % 4) != 0;
      sym_in       = ($urandom % 8 < 7) ? (($urandom % 2) ? SYM_C : SYM_A) : SYM_G;
      match_ready  = ($urandom % 3) != 0;
      pattern_load = ($urandom % 150) == 0;
      for (int j = 0; j < K; j++) rp[2*j +: 2] = ($urandom % 2) ? SYM_C : SYM_A;
      pattern = rp;
      cycle("rand");
    end
    sym_in_valid = 0; pattern_load = 0; match_ready = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
